// File: rtl/multiplicador_shift_add_7bits_pkg.sv
// Shared definitions for the 7-bit shift-and-add multiply-accumulate unit.
//   N_OP    : operand width (Q_in, B_in, R_in)
//   P_W     : result width (2*N_OP), wide enough for (2^N-1)^2 + (2^N-1)
//   CNT_W   : iteration counter width
//   state_t : control states IDLE / CALC / DONE
package multiplicador_shift_add_7bits_pkg;

  localparam int N_OP  = 7;
  localparam int P_W   = 2 * N_OP;
  localparam int CNT_W = $clog2(N_OP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplicador_shift_add_7bits.sv
// Sequential shift-and-add multiply-accumulate: P = Q_in * B_in + R_in.
// Rebuilds the dividend from the outputs of the 7-bit restoring divider and
// doubles as a plain 7x7 multiplier when R_in = 0.
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset (0 = reset)
//   start : request, sampled only in IDLE or DONE
//   Q_in  : multiplier (quotient), N_OP bits
//   B_in  : multiplicand (divisor), N_OP bits
//   R_in  : addend (remainder), N_OP bits, zero-extended
//   P     : result, P_W bits, updated only on CALC->DONE or reset
//   done  : result valid, level, held until the next start or reset
//   busy  : high while the iteration is running
module multiplicador_shift_add_7bits
  import multiplicador_shift_add_7bits_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OP-1:0]  Q_in,
  input  logic [N_OP-1:0]  B_in,
  input  logic [N_OP-1:0]  R_in,
  output logic [P_W-1:0]   P,
  output logic             done,
  output logic             busy
);

  state_t             state_reg;
  logic [P_W-1:0]     acc_reg;
  logic [P_W-1:0]     mcand_reg;
  logic [N_OP-1:0]    mult_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [P_W-1:0]     sum_next;

  // Single 2N-bit adder: the result never exceeds 2^P_W - 1, so no carry-out.
  assign sum_next = acc_reg + (mult_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mult_reg  <= '0;
      cnt_reg   <= '0;
      P         <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // DONE accepts a new start directly, clearing done on the same edge.
          if (start) begin
            acc_reg   <= {{N_OP{1'b0}}, R_in};
            mcand_reg <= {{N_OP{1'b0}}, B_in};
            mult_reg  <= Q_in;
            cnt_reg   <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          // start is deliberately not looked at here: no restart, no queuing.
          acc_reg   <= sum_next;
          mcand_reg <= mcand_reg << 1;
          mult_reg  <= mult_reg >> 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(N_OP - 1)) begin
            // Final iteration: publish the sum directly so P never shows a
            // partial accumulation.
            P         <= sum_next;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_shift_add_7bits.sv
module tb_multiplicador_shift_add_7bits;

  localparam int N   = 7;
  localparam int LAT = 7;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  Q_in, B_in, R_in;
  logic [13:0] P;
  logic        done, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int exp_p;
    int start_cyc;
    int q, b, r;
  } item_t;

  item_t sb[$];

  multiplicador_shift_add_7bits dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Q_in  (Q_in),
    .B_in  (B_in),
    .R_in  (R_in),
    .P     (P),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge of done pops the scoreboard and checks
  // result value and start-to-done latency; P must be stable otherwise.
  initial begin : monitor
    logic        done_prev;
    logic        rst_prev;
    logic [13:0] p_prev;
    item_t       it;
    done_prev = 1'b0;
    rst_prev  = 1'b0;
    p_prev    = '0;
    forever begin
      @(negedge clk);
      if (rst && rst_prev) begin
        if (done && !done_prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            it = sb.pop_front();
            chk($sformatf("P q=%0d b=%0d r=%0d", it.q, it.b, it.r), int'(P), it.exp_p);
            chk("latency", cyc - it.start_cyc, LAT);
            chk("busy_low_at_done", int'(busy), 0);
          end
        end else if (P != p_prev) begin
          chk("P_changed_outside_done", int'(P), int'(p_prev));
        end
      end
      done_prev = done;
      rst_prev  = rst;
      p_prev    = P;
    end
  end

  // Issue one operation; optionally disturb start/operands mid-CALC.
  task automatic do_op(input int q, input int b, input int r, input bit disturb);
    item_t it;
    bit    seen;
    @(negedge clk);
    Q_in  = 7'(q);
    B_in  = 7'(b);
    R_in  = 7'(r);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    it.exp_p     = q * b + r;
    it.start_cyc = cyc;
    it.q = q; it.b = b; it.r = r;
    sb.push_back(it);
    chk("busy_after_start", int'(busy), 1);
    chk("done_cleared_at_start", int'(done), 0);
    Q_in = 7'($urandom_range(0, 127));
    B_in = 7'($urandom_range(0, 127));
    R_in = 7'($urandom_range(0, 127));
    if (disturb) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      Q_in  = 7'($urandom_range(0, 127));
      B_in  = 7'($urandom_range(0, 127));
      R_in  = 7'($urandom_range(0, 127));
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin : stim
    int a, b;
    rst   = 1'b0;
    start = 1'b1;
    Q_in  = 7'd5;
    B_in  = 7'd5;
    R_in  = 7'd5;
    #50;
    chk("reset_P", int'(P), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_P", int'(P), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);

    // Directed cases
    do_op(4, 30, 7, 1'b0);
    do_op(1, 60, 0, 1'b0);
    do_op(5, 2, 0, 1'b0);
    do_op(0, 10, 0, 1'b0);
    do_op(0, 99, 55, 1'b0);
    do_op(127, 127, 127, 1'b0);
    do_op(127, 127, 0, 1'b0);

    // Start pulse and operand changes mid-CALC are ignored
    do_op(9, 13, 4, 1'b1);

    // Abort mid-CALC with asynchronous reset
    @(negedge clk);
    Q_in  = 7'd100;
    B_in  = 7'd100;
    R_in  = 7'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_P", int'(P), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_abort_done", int'(done), 0);
    do_op(3, 3, 2, 1'b0);

    // Divider round-trip: quotient*divisor + remainder rebuilds the dividend
    do_op(127 / 30, 30, 127 % 30, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, 127);
      b = $urandom_range(1, 127);
      do_op(a / b, b, a % b, 1'b0);
    end

    // Randomized multiply-accumulate, some with disturbance
    for (int i = 0; i < 20; i++) begin
      do_op($urandom_range(0, 127), $urandom_range(0, 127),
            (i % 3 == 0) ? 0 : $urandom_range(0, 127), (i % 5 == 4));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
